// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths, requester indices and a round-robin helper for the GPR
// writeback arbiter.
package gpr_wb_arbiter_pkg;

    localparam int AW_REG   = 5;
    localparam int DW_WORD  = 32;
    localparam int NREQ_DEF = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    // Index that gets first look after requester g has been served.
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback requester bus, GPR write port, reservation and operand-hazard
// signals shared by the arbiter and its neighbours.
interface gpr_wb_arbiter_if
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_REG,
    parameter int DW   = DW_WORD
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_sel;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic               wb_we;
    logic [AW-1:0]      wb_sel;
    logic [DW-1:0]      wb_data;

    logic               rsv_valid;
    logic [AW-1:0]      rsv_sel;
    logic               rsv_ready;

    logic [AW-1:0]      rd_rs_sel;
    logic [AW-1:0]      rd_rt_sel;
    logic               hz_stall;

    modport slave (
        input  req_valid, req_sel, req_data,
        input  rsv_valid, rsv_sel,
        input  rd_rs_sel, rd_rt_sel,
        output req_ready,
        output wb_we, wb_sel, wb_data,
        output rsv_ready,
        output hz_stall
    );

    modport master (
        output req_valid, req_sel, req_data,
        output rsv_valid, rsv_sel,
        output rd_rs_sel, rd_rt_sel,
        input  req_ready,
        input  wb_we, wb_sel, wb_data,
        input  rsv_ready,
        input  hz_stall
    );

endinterface

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// NREQ-wide round-robin grant: search starts at rr_ptr and wraps; the pointer
// moves just past the winner whenever a grant is issued.
module gpr_wb_arbiter_rr_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int PW   = (NREQ > 2) ? 2 : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [PW-1:0] rr_ptr;
    logic [PW:0]   cand;
    logic [PW-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            cand_idx = cand[PW-1:0];
            if (!gnt_any && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
                gnt_any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= PW'(rr_next(int'(gnt_idx), NREQ));
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port among NREQ writeback requesters and keeps
// the pending-write scoreboard that drives operand hazard stalls.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_REG,
    parameter int DW   = DW_WORD
) (
    input  logic           clk,
    input  logic           rst,
    gpr_wb_arbiter_if.slave bus
);

    localparam int PW   = (NREQ > 2) ? 2 : 1;
    localparam int NREG = 1 << AW;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   g_sel;
    logic [DW-1:0]   g_data;

    logic            wb_we_q;
    logic [AW-1:0]   wb_sel_q;
    logic [DW-1:0]   wb_data_q;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            rsv_set;

    gpr_wb_arbiter_rr_arbiter #(
        .NREQ    (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.req_ready = gnt;
    assign g_sel         = bus.req_sel[int'(gnt_idx)*AW +: AW];
    assign g_data        = bus.req_data[int'(gnt_idx)*DW +: DW];

    // r0 grants are consumed but never drive the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q <= gnt_any && (g_sel != '0);
            if (gnt_any) begin
                wb_sel_q  <= g_sel;
                wb_data_q <= g_data;
            end
        end
    end

    assign bus.wb_we   = wb_we_q;
    assign bus.wb_sel  = wb_sel_q;
    assign bus.wb_data = wb_data_q;

    // r0 reservations are always accepted but never mark anything busy.
    assign bus.rsv_ready = bus.rsv_valid &&
                           ((bus.rsv_sel == '0) || !busy[bus.rsv_sel]);
    assign rsv_set       = bus.rsv_ready && (bus.rsv_sel != '0);

    // Commit clears first so a same-cycle reservation of that register wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_we_q) begin
            busy_nxt[wb_sel_q] = 1'b0;
        end
        if (rsv_set) begin
            busy_nxt[bus.rsv_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign bus.hz_stall = ((bus.rd_rs_sel != '0) && busy[bus.rd_rs_sel]) ||
                          ((bus.rd_rt_sel != '0) && busy[bus.rd_rt_sel]);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios plus random traffic, predicted
// by a queue-based reference model and checked by a negedge monitor.
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpr_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    gpr_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            rsv;
        logic            hz;
    } comb_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] sel;
        logic [DW-1:0] data;
    } wb_t;

    comb_t comb_q[$];
    wb_t   wb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // requester and issue-side stimulus state
    logic          rq_v [NREQ];
    logic [AW-1:0] rq_s [NREQ];
    logic [DW-1:0] rq_d [NREQ];
    logic          t_rsv_v;
    logic [AW-1:0] t_rsv_s, t_rs, t_rt;

    // reference model: who was served last, which registers are pending,
    // and the write that is on the GPR port this cycle
    int m_last;
    bit m_busy [32];
    bit m_wv;
    int m_ws;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = rq_v[i];
            bus.req_sel[i*AW +: AW]  = rq_s[i];
            bus.req_data[i*DW +: DW] = rq_d[i];
        end
        bus.rsv_valid = t_rsv_v;
        bus.rsv_sel   = t_rsv_s;
        bus.rd_rs_sel = t_rs;
        bus.rd_rt_sel = t_rt;
    endtask

    task automatic set_rq(input int i, input logic [AW-1:0] s, input logic [DW-1:0] d);
        rq_v[i] = 1'b1;
        rq_s[i] = s;
        rq_d[i] = d;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NREQ; i++) begin
            rq_v[i] = 1'b0;
            rq_s[i] = '0;
            rq_d[i] = '0;
        end
        t_rsv_v = 1'b0;
        t_rsv_s = '0;
        t_rs    = '0;
        t_rt    = '0;
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_wv = 1'b0;
        m_ws = 0;
        comb_q.delete();
        wb_q.delete();
    endtask

    // One clock cycle: apply stimulus, predict, wait for the edge, advance model.
    task automatic cycle();
        int    g;
        int    j;
        comb_t c;
        wb_t   w;
        drive();
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (g < 0 && rq_v[j]) g = j;
        end
        c.gnt = '0;
        if (g >= 0) c.gnt[g] = 1'b1;
        c.rsv = t_rsv_v && (t_rsv_s == 0 || !m_busy[t_rsv_s]);
        c.hz  = (t_rs != 0 && m_busy[t_rs]) || (t_rt != 0 && m_busy[t_rt]);
        comb_q.push_back(c);
        if (g >= 0 && rq_s[g] != 0) begin
            w.cyc  = cyc + 1;
            w.sel  = rq_s[g];
            w.data = rq_d[g];
            wb_q.push_back(w);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (m_wv) m_busy[m_ws] = 1'b0;
        if (c.rsv && t_rsv_s != 0) m_busy[t_rsv_s] = 1'b1;
        m_wv = (g >= 0) && (rq_s[g] != 0);
        if (g >= 0) begin
            m_ws    = int'(rq_s[g]);
            m_last  = g;
            rq_v[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b0;
        clear_stim();
        drive();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst wb_we", bus.wb_we, 1'b0);
        chk("rst hz_stall", bus.hz_stall, 1'b0);
        chk("rst req_ready", bus.req_ready, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        comb_t c;
        wb_t   w;
        if (mon_en) begin
            if (comb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL comb_q: no expectation queued at cycle %0d", cyc);
            end else begin
                c = comb_q.pop_front();
                chk("req_ready", bus.req_ready, c.gnt);
                chk("rsv_ready", bus.rsv_ready, c.rsv);
                chk("hz_stall", bus.hz_stall, c.hz);
            end
            if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
                w = wb_q.pop_front();
                chk("wb_we", bus.wb_we, 1'b1);
                chk("wb_sel", bus.wb_sel, w.sel);
                chk("wb_data", bus.wb_data, w.data);
            end else begin
                chk("wb_we idle", bus.wb_we, 1'b0);
            end
        end
    end

    initial begin
        clear_stim();
        drive();
        do_reset();

        // idle after reset
        repeat (4) cycle();

        // single ALU write
        set_rq(int'(WB_ALU), 5'd5, 32'h1234_5678);
        repeat (3) cycle();

        // all three requesters continuously valid from a fresh pointer
        do_reset();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq_v[i]) set_rq(i, AW'(10 + i), DW'(32'hA000_0000 + n * 16 + i));
            end
            cycle();
        end
        repeat (2) cycle();

        // reservation of r8, hazard, WAW stall, MDU commit
        t_rsv_v = 1'b1; t_rsv_s = 5'd8;
        cycle();
        t_rsv_v = 1'b0; t_rs = 5'd8;
        cycle();
        t_rsv_v = 1'b1;
        cycle();
        t_rsv_v = 1'b0;
        set_rq(int'(WB_MDU), 5'd8, 32'hDEAD_BEEF);
        repeat (3) cycle();
        t_rs = '0;

        // r0 write and r0 reservation
        set_rq(int'(WB_LSU), 5'd0, 32'hFFFF_FFFF);
        repeat (2) cycle();
        t_rsv_v = 1'b1; t_rsv_s = 5'd0; t_rt = 5'd0;
        cycle();
        t_rsv_v = 1'b0;
        cycle();

        // pointer wrap from 2 to 0
        do_reset();
        set_rq(int'(WB_MDU), 5'd3, 32'h0000_0033);
        cycle();
        set_rq(int'(WB_ALU), 5'd4, 32'h0000_0044);
        set_rq(int'(WB_MDU), 5'd6, 32'h0000_0066);
        repeat (4) cycle();

        // random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq_v[i] && $urandom_range(0, 99) < 60)
                    set_rq(i, AW'($urandom_range(0, 31)), DW'($urandom));
            end
            t_rsv_v = ($urandom_range(0, 99) < 35);
            t_rsv_s = AW'($urandom_range(0, 31));
            t_rs    = AW'($urandom_range(0, 31));
            t_rt    = AW'($urandom_range(0, 31));
            cycle();
        end
        clear_stim();
        repeat (3) cycle();

        // asynchronous reset while a write is on the port
        do_reset();
        set_rq(int'(WB_ALU), 5'd12, 32'hAAAA_5555);
        t_rsv_v = 1'b1; t_rsv_s = 5'd9;
        cycle();
        t_rsv_v = 1'b0; t_rs = 5'd9;
        drive();
        mon_en = 1'b0;
        #3;
        chk("pre-rst wb_we", bus.wb_we, 1'b1);
        chk("pre-rst hz_stall", bus.hz_stall, 1'b1);
        rst = 1'b0;
        #1;
        chk("async rst wb_we", bus.wb_we, 1'b0);
        chk("async rst wb_sel", bus.wb_sel, '0);
        chk("async rst hz_stall", bus.hz_stall, 1'b0);
        do_reset();
        set_rq(int'(WB_LSU), 5'd7, 32'h0BAD_F00D);
        repeat (3) cycle();

        mon_en = 1'b0;
        chk("wb_q drained", 64'(wb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
